fir_out_capture: RTL and testbench
==================================

Name: fir_out_capture

Overview:
- Output capture stage directly downstream of the FIR tap/accumulate path and its cycle counter.
- On each `capture_en` pulse (the counter's `count_reach`), samples the wide signed accumulator, rounds and narrows it to the output width, and buffers it in a small FIFO.
- Presents buffered samples on a `valid`/`ready` stream interface.
- Replaces the bare output DFF so no filter result is lost when the consumer stalls.

Parameters:
- ACC_W, 20, accumulator input width (signed two's complement).
- OUT_W, 8, output sample width (signed); must satisfy OUT_W <= ACC_W - SHIFT.
- SHIFT, 8, arithmetic right shift (fractional bits dropped); must be >= 1.
- DEPTH, 4, FIFO depth in entries; power of two, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- capture_en  in  1  capture strobe; one capture per cycle it is high.
- acc_in  in  ACC_W  signed accumulator value, sampled when capture_en=1.
- out_valid  out  1  FIFO head holds a sample.
- out_ready  in  1  consumer accepts the head when out_valid=1.
- out_data  out  OUT_W  FIFO head sample (signed).
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- drop_cnt  out  8  saturating count of samples discarded because the FIFO was full.

Behaviour:
- Reset (async, active-high): stage-1 valid=0, FIFO emptied, rd/wr pointers=0.
  - Outputs: out_valid=0, out_data=0, level=0, full=0, drop_cnt=0.
  - Reset mid-operation discards the in-flight stage-1 sample and all FIFO contents.
- Stage 1 (edge N, capture_en=1):
  - r = (sign-extend acc_in to ACC_W+1) + 2^(SHIFT-1).
  - r >>> SHIFT (arithmetic): round-half-up toward +inf.
  - The narrowing rule (see Optional Feature) produces an OUT_W value.
  - Value registered with s1_valid=1. With capture_en=0, s1_valid=0 at edge N.
- Stage 2 (edge N+1): if s1_valid=1, push into the FIFO.
  - Push is accepted if level<DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop: push accepted, level stays DEPTH).
  - Otherwise the sample is dropped and drop_cnt increments, holding at 255.
- Latency: capture at edge N with an empty FIFO gives out_valid=1 and out_data valid after edge N+1 (visible during cycle N+1..N+2).
  - Back-to-back captures every cycle are supported at full throughput.
- Pop: occurs at a rising edge when out_valid=1 and out_ready=1. The head advances, and out_data shows the next entry or holds its last value when empty.
  - out_ready with out_valid=0 has no effect.
  - out_data is stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop with level in 1..DEPTH-1: level unchanged, order preserved.
- Simultaneous push and pop with level=0: the sample is written and appears next cycle; no bypass.
- Pointers wrap modulo DEPTH. full and level derive from the occupancy counter and are updated at the same edge as push/pop.
- No combinational path from out_ready to any output.

Optional Feature:
- Macro FIR_OUT_SAT_EN.
- Defined: narrowing saturates. Shifted values above 2^(OUT_W-1)-1 clamp to that maximum; values below -2^(OUT_W-1) clamp to that minimum.
- Undefined: narrowing truncates to the low OUT_W bits (two's complement wrap).
- All other behaviour, including latency, is identical in both builds.

Test Plan:
- Reset asserted mid-stream, with level=3 and s1_valid=1 -> all outputs 0 immediately (asynchronously); the first capture after deassert appears as the sole FIFO entry.
- out_ready=1, capture_en=1 one cycle with acc_in=0x00480 -> out_valid one edge later, out_data=0x05. Repeat with acc_in=0xFFE80 (-384) -> out_data=0xFF.
- acc_in=0x7FFFF -> out_data=0x00 without FIR_OUT_SAT_EN, 0x7F with it. acc_in=0x80000 -> out_data=0x00 without, 0x80 with.
- out_ready=0, five single-cycle captures of values 1..5 (acc_in=n<<8) -> level=4, full=1, drop_cnt=1. Then out_ready=1 drains 0x01,0x02,0x03,0x04 in order, and level returns to 0.
- FIFO full and out_ready=1, capture_en held high for 8 cycles -> no drops, drop_cnt unchanged, output order equals capture order, level stays 4 throughout.
- out_ready=0, 300 captures -> drop_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/fir_out_capture.sv
// fir_out_capture: rounds/narrows the FIR accumulator on capture_en and
// buffers results in a small FIFO presented as a valid/ready stream.
// Build option: define FIR_OUT_SAT_EN to saturate instead of wrap on narrowing.
// Ports:
//   clk, reset            - clock, async active-high reset
//   capture_en, acc_in    - capture strobe and signed accumulator value
//   out_valid/out_ready   - output stream handshake, out_data = FIFO head
//   level, full           - FIFO occupancy (0..DEPTH) and full flag
//   drop_cnt              - saturating count of samples lost to a full FIFO
module fir_out_capture #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic [ACC_W-1:0]         acc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [7:0]               drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shf;
    logic [OUT_W-1:0]      narrow;
    logic                  unused_shf;

`ifdef FIR_OUT_SAT_EN
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
`endif

    // One extra bit of headroom so adding the half-LSB cannot overflow.
    always_comb begin
        rnd = signed'({acc_in[ACC_W-1], acc_in} + HALF);
        shf = rnd >>> SHIFT;
`ifdef FIR_OUT_SAT_EN
        if (shf > SAT_MAX) begin
            narrow = SAT_MAX[OUT_W-1:0];
        end else if (shf < SAT_MIN) begin
            narrow = SAT_MIN[OUT_W-1:0];
        end else begin
            narrow = shf[OUT_W-1:0];
        end
`else
        narrow = shf[OUT_W-1:0];
`endif
    end

    assign unused_shf = ^shf;

    logic             s1_valid;
    logic [OUT_W-1:0] s1_data;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;

    assign out_valid = (level != '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = s1_valid & (~full | pop);
    assign drop      = s1_valid & ~push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            out_data <= '0;
        end else begin
            s1_valid <= capture_en;
            if (capture_en) begin
                s1_data <= narrow;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            // Registered head: the pushed sample becomes head when the FIFO
            // is (or becomes) empty, otherwise the next stored entry.
            // With no entries left the last value is held.
            if (push && (level == '0 || (level == LVL_W'(1) && pop))) begin
                out_data <= s1_data;
            end else if (pop && level > LVL_W'(1)) begin
                out_data <= mem[rd_ptr + PTR_W'(1)];
            end
        end
    end

endmodule

// File: tb/tb_fir_out_capture.sv
// tb_fir_out_capture: directed scoreboard bench for fir_out_capture.
// Expected samples are queued at issue; a negedge monitor checks each pop.
module tb_fir_out_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        capture_en;
    logic [19:0] acc_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic        full;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    fir_out_capture dut (
        .clk        (clk),
        .reset      (reset),
        .capture_en (capture_en),
        .acc_in     (acc_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .full       (full),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [19:0] a, input logic [7:0] e,
                       input bit keep);
        capture_en = 1'b1;
        acc_in     = a;
        if (keep) exp_q.push_back(e);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        capture_en = 1'b0;
        out_ready  = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(n < 50), 32'd1);
        chk("level_drained", 32'(level), 32'd0);
    endtask

    // Monitor: a pop happens at the next posedge whenever valid&ready here.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h expected none",
                         out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        capture_en = 1'b0;
        out_ready  = 1'b0;
        acc_in     = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Rounding and latency
        out_ready = 1'b1;
        cap(20'h00480, 8'h05, 1);
        capture_en = 1'b0;
        chk("lat_early_valid", 32'(out_valid), 0);
        tick();
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'h05);
        drain();
        cap(20'hFFE80, 8'hFF, 1);
        capture_en = 1'b0;
        drain();
`ifdef FIR_OUT_SAT_EN
        cap(20'h7FFFF, 8'h7F, 1);
        cap(20'h80000, 8'h80, 1);
`else
        cap(20'h7FFFF, 8'h00, 1);
        cap(20'h80000, 8'h00, 1);
`endif
        capture_en = 1'b0;
        drain();

        // Overflow by one with stalled consumer
        out_ready = 1'b0;
        for (int n = 1; n <= 5; n++) cap(20'(n << 8), 8'(n), n <= 4);
        capture_en = 1'b0;
        tick();
        tick();
        chk("ovf_level", 32'(level), 4);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_drop", 32'(drop_cnt), 1);
        drain();

        // Full FIFO, streaming push and pop every cycle
        out_ready = 1'b0;
        for (int n = 10; n <= 13; n++) cap(20'(n << 8), 8'(n), 1);
        capture_en = 1'b0;
        tick();
        tick();
        chk("stream_pre_full", 32'(full), 1);
        cap(20'(20 << 8), 8'd20, 1);
        out_ready = 1'b1;
        for (int n = 21; n <= 27; n++) begin
            cap(20'(n << 8), 8'(n), 1);
            chk("stream_level", 32'(level), 4);
        end
        capture_en = 1'b0;
        tick();
        chk("stream_level_last", 32'(level), 4);
        chk("stream_drop", 32'(drop_cnt), 1);
        drain();

        // Async reset mid-stream with stage-1 occupied
        out_ready = 1'b0;
        for (int n = 30; n <= 32; n++) cap(20'(n << 8), 8'(n), 1);
        capture_en = 1'b0;
        tick();
        tick();
        chk("pre_rst_level", 32'(level), 3);
        cap(20'(33 << 8), 8'd33, 0);
        capture_en = 1'b0;
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_full", 32'(full), 0);
        chk("arst_drop", 32'(drop_cnt), 0);
        #2 reset = 1'b0;
        tick();
        cap(20'(40 << 8), 8'h28, 1);
        capture_en = 1'b0;
        tick();
        chk("post_rst_level", 32'(level), 1);
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_data", 32'(out_data), 32'h28);
        drain();

        // Drop counter saturation
        out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i < 4) cap(20'((i + 1) << 8), 8'(i + 1), 1);
            else cap(20'h00480, 8'h05, 0);
        end
        capture_en = 1'b0;
        tick();
        tick();
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        chk("drop_sat_level", 32'(level), 4);
        drain();
        chk("drop_hold", 32'(drop_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
